// File: rtl/ppa_pkg.sv
// Shared definitions for the parallel-prefix arithmetic blocks.
// Provides the default datapath width, the per-bit generate/propagate pair
// and the prefix combine operator used by every Kogge-Stone tree.
package ppa_pkg;

    localparam int PPA_WIDTH = 16;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix combine: high group (hi) absorbs the adjacent lower group (lo).
    function automatic gp_t ppa_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ppa_ks_prefix_tree.sv
// Combinational Kogge-Stone prefix tree.
// grp_g_o[i] / grp_p_o[i] are the group generate / propagate of bits i..0,
// built in $clog2(WIDTH) levels where level k combines with span 2^k.
module ppa_ks_prefix_tree
    import ppa_pkg::*;
#(
    parameter int WIDTH = PPA_WIDTH
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] g_i,
    output logic [WIDTH-1:0] grp_p_o,
    output logic [WIDTH-1:0] grp_g_o
);

    localparam int LEVELS = $clog2(WIDTH);

    gp_t lvl_s [LEVELS+1][WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
        assign lvl_s[0][i] = {g_i[i], p_i[i]};
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_comb
                assign lvl_s[k+1][i] = ppa_combine(lvl_s[k][i], lvl_s[k][i-(1<<k)]);
            end else begin : g_pass
                assign lvl_s[k+1][i] = lvl_s[k][i];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_out
        assign grp_g_o[i] = lvl_s[LEVELS][i].g;
        assign grp_p_o[i] = lvl_s[LEVELS][i].p;
    end

endmodule

// File: rtl/ppa_ks_subtractor_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor: d = a - b - bin (mod 2^WIDTH)
// computed as a + ~b + ~bin, with a valid/ready stream and full back-pressure.
// S1: p/g/cin, S2: prefix tree outputs, S3: difference, borrow and flags.
// Optional macro PPA_SUB_FLAGS_EN builds the zero/neg/ovf flags and the
// operand msb pipeline; without it those ports are tied to 0.
module ppa_ks_subtractor_pipe
    import ppa_pkg::*;
#(
    parameter int WIDTH = PPA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    // Stage enables: a stage may load when empty or when its successor moves.
    logic en1_s, en2_s, en3_s;

    // Stage 1 state
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] p1_q, p1_d;
    logic [WIDTH-1:0] g1_q, g1_d;
    logic             cin1_q, cin1_d;

    // Stage 2 state
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] gg2_q, gg2_d;
    logic [WIDTH-1:0] gp2_q, gp2_d;
    logic [WIDTH-1:0] p2_q, p2_d;
    logic             cin2_q, cin2_d;

    // Stage 3 state
    logic             v3_q, v3_d;
    logic [WIDTH-1:0] d3_q, d3_d;
    logic             bout3_q, bout3_d;

    // Prefix tree outputs and final carry chain
    logic [WIDTH-1:0] tree_g_s, tree_p_s;
    logic [WIDTH:0]   c_s;
    logic [WIDTH-1:0] diff_s;
    logic             borrow_s;

    assign en3_s    = ~v3_q | out_ready;
    assign en2_s    = ~v2_q | en3_s;
    assign en1_s    = ~v1_q | en2_s;
    assign in_ready = en1_s;

    ppa_ks_prefix_tree #(
        .WIDTH (WIDTH)
    ) u_tree (
        .p_i     (p1_q),
        .g_i     (g1_q),
        .grp_p_o (tree_p_s),
        .grp_g_o (tree_g_s)
    );

    // S1 next state: invert b and bin so the adder prefix structure subtracts.
    always_comb begin
        v1_d   = v1_q;
        p1_d   = p1_q;
        g1_d   = g1_q;
        cin1_d = cin1_q;
        if (en1_s) begin
            v1_d   = in_valid;
            p1_d   = a ^ ~b;
            g1_d   = a & ~b;
            cin1_d = ~bin;
        end else begin
            v1_d   = v1_q;
        end
    end

    // S2 next state: capture group G/P from the tree along with p and cin.
    always_comb begin
        v2_d   = v2_q;
        gg2_d  = gg2_q;
        gp2_d  = gp2_q;
        p2_d   = p2_q;
        cin2_d = cin2_q;
        if (en2_s) begin
            v2_d   = v1_q;
            gg2_d  = tree_g_s;
            gp2_d  = tree_p_s;
            p2_d   = p1_q;
            cin2_d = cin1_q;
        end else begin
            v2_d   = v2_q;
        end
    end

    // Carries from group G/P and cin; difference and borrow-out.
    always_comb begin
        c_s    = {(WIDTH+1){1'b0}};
        c_s[0] = cin2_q;
        for (int i = 0; i < WIDTH; i++) begin
            c_s[i+1] = gg2_q[i] | (gp2_q[i] & cin2_q);
        end
        diff_s   = c_s[WIDTH-1:0] ^ p2_q;
        borrow_s = ~c_s[WIDTH];
    end

    // S3 next state: register the result for the output port.
    always_comb begin
        v3_d    = v3_q;
        d3_d    = d3_q;
        bout3_d = bout3_q;
        if (en3_s) begin
            v3_d    = v2_q;
            d3_d    = diff_s;
            bout3_d = borrow_s;
        end else begin
            v3_d    = v3_q;
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            p1_q    <= {WIDTH{1'b0}};
            g1_q    <= {WIDTH{1'b0}};
            cin1_q  <= 1'b0;
            v2_q    <= 1'b0;
            gg2_q   <= {WIDTH{1'b0}};
            gp2_q   <= {WIDTH{1'b0}};
            p2_q    <= {WIDTH{1'b0}};
            cin2_q  <= 1'b0;
            v3_q    <= 1'b0;
            d3_q    <= {WIDTH{1'b0}};
            bout3_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            p1_q    <= p1_d;
            g1_q    <= g1_d;
            cin1_q  <= cin1_d;
            v2_q    <= v2_d;
            gg2_q   <= gg2_d;
            gp2_q   <= gp2_d;
            p2_q    <= p2_d;
            cin2_q  <= cin2_d;
            v3_q    <= v3_d;
            d3_q    <= d3_d;
            bout3_q <= bout3_d;
        end
    end

    assign out_valid = v3_q;
    assign d         = d3_q;
    assign bout      = bout3_q;

`ifdef PPA_SUB_FLAGS_EN
    logic a_msb1_q, a_msb1_d, b_msb1_q, b_msb1_d;
    logic a_msb2_q, a_msb2_d, b_msb2_q, b_msb2_d;
    logic zero3_q, zero3_d, neg3_q, neg3_d, ovf3_q, ovf3_d;

    // Operand msbs follow the data through S1/S2; flags are formed into S3.
    always_comb begin
        a_msb1_d = a_msb1_q;
        b_msb1_d = b_msb1_q;
        a_msb2_d = a_msb2_q;
        b_msb2_d = b_msb2_q;
        zero3_d  = zero3_q;
        neg3_d   = neg3_q;
        ovf3_d   = ovf3_q;
        if (en1_s) begin
            a_msb1_d = a[WIDTH-1];
            b_msb1_d = b[WIDTH-1];
        end else begin
            a_msb1_d = a_msb1_q;
        end
        if (en2_s) begin
            a_msb2_d = a_msb1_q;
            b_msb2_d = b_msb1_q;
        end else begin
            a_msb2_d = a_msb2_q;
        end
        if (en3_s) begin
            zero3_d = (diff_s == {WIDTH{1'b0}});
            neg3_d  = diff_s[WIDTH-1];
            ovf3_d  = (a_msb2_q ^ b_msb2_q) & (a_msb2_q ^ diff_s[WIDTH-1]);
        end else begin
            zero3_d = zero3_q;
        end
    end

    // Flag pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb1_q <= 1'b0;
            b_msb1_q <= 1'b0;
            a_msb2_q <= 1'b0;
            b_msb2_q <= 1'b0;
            zero3_q  <= 1'b0;
            neg3_q   <= 1'b0;
            ovf3_q   <= 1'b0;
        end else begin
            a_msb1_q <= a_msb1_d;
            b_msb1_q <= b_msb1_d;
            a_msb2_q <= a_msb2_d;
            b_msb2_q <= b_msb2_d;
            zero3_q  <= zero3_d;
            neg3_q   <= neg3_d;
            ovf3_q   <= ovf3_d;
        end
    end

    assign zero = zero3_q;
    assign neg  = neg3_q;
    assign ovf  = ovf3_q;
`else
    assign zero = 1'b0;
    assign neg  = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_ppa_ks_subtractor_pipe.sv
// Self-checking bench for ppa_ks_subtractor_pipe (WIDTH = 16).
// Directed vector table, random stream, back-pressure and mid-stream reset,
// all checked through a scoreboard queue fed when operands are accepted.
module tb_ppa_ks_subtractor_pipe;

    localparam int WIDTH = 16;
`ifdef PPA_SUB_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             neg;
    logic             ovf;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             zero;
        logic             neg;
        logic             ovf;
    } res_t;

    typedef struct {
        res_t r;
        int   acc_cyc;
        bit   lat;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
        res_t             r;
    } vec_t;

    exp_t q_exp[$];
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_acc  = 0;
    int   n_out  = 0;
    bit   bp_done;

    ppa_ks_subtractor_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic binv);
        res_t r;
        logic [WIDTH:0] df;
        df     = {1'b0, av} - {1'b0, bv} - {{WIDTH{1'b0}}, binv};
        r.d    = df[WIDTH-1:0];
        r.bout = df[WIDTH];
        r.zero = (df[WIDTH-1:0] == {WIDTH{1'b0}}) & FLAGS_ON;
        r.neg  = df[WIDTH-1] & FLAGS_ON;
        r.ovf  = (av[WIDTH-1] ^ bv[WIDTH-1]) & (av[WIDTH-1] ^ df[WIDTH-1]) & FLAGS_ON;
        return r;
    endfunction

    function automatic res_t mk(input logic [WIDTH-1:0] dv, input logic bo, input logic z, input logic n, input logic o);
        res_t r;
        r.d = dv; r.bout = bo;
        r.zero = z & FLAGS_ON; r.neg = n & FLAGS_ON; r.ovf = o & FLAGS_ON;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare each transferred result with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual d=%0h expected no result", d);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("d",    {16'h0, d},    {16'h0, e.r.d});
                chk("bout", {31'h0, bout}, {31'h0, e.r.bout});
                chk("zero", {31'h0, zero}, {31'h0, e.r.zero});
                chk("neg",  {31'h0, neg},  {31'h0, e.r.neg});
                chk("ovf",  {31'h0, ovf},  {31'h0, e.r.ovf});
                if (e.lat) chk("latency", cyc - e.acc_cyc, 32'd3);
                n_out++;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic binv,
                        input res_t ex, input bit lat);
        bit acc;
        exp_t e;
        acc = 1'b0;
        a = av; b = bv; bin = binv; in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                e.r = ex; e.acc_cyc = cyc; e.lat = lat;
                q_exp.push_back(e);
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual not accepted expected accepted a=%0h b=%0h", av, bv);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q_exp.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_empty", q_exp.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb, saved_d;
        logic             rbin;
        int               base_acc, base_out;

        vecs[0] = '{16'h0005, 16'h0003, 1'b0, mk(16'h0002, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[1] = '{16'h0003, 16'h0005, 1'b0, mk(16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0)};
        vecs[2] = '{16'h1234, 16'h1234, 1'b0, mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0)};
        vecs[3] = '{16'h1234, 16'h1234, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0)};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0)};
        vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1'b1, 1'b0, 1'b1, 1'b1)};
        vecs[7] = '{16'hFFFF, 16'h0000, 1'b0, mk(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0)};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0; bp_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_d",         {16'h0, d},         32'd0);
        chk("rst_flags",     {28'h0, bout, zero, neg, ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);

        // Directed table, back-to-back with out_ready high
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].r, 1'b1);
        end
        in_valid = 1'b0;
        drain();

        // Random stream: latency check on each result also proves 1/cycle
        for (int i = 0; i < 100; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom);
            send(ra, rb, rbin, model(ra, rb, rbin), 1'b1);
        end
        in_valid = 1'b0;
        drain();

        // Back-pressure: 5 sets offered with out_ready low
        base_acc = n_acc; base_out = n_out;
        out_ready = 1'b0;
        fork
            begin
                logic [WIDTH-1:0] fa, fb;
                for (int i = 0; i < 5; i++) begin
                    fa = WIDTH'($urandom); fb = WIDTH'($urandom);
                    send(fa, fb, 1'b0, model(fa, fb, 1'b0), 1'b0);
                end
                in_valid = 1'b0;
                bp_done = 1'b1;
            end
        join_none
        repeat (10) @(posedge clk);
        #1;
        chk("bp_accepted",  n_acc - base_acc, 32'd3);
        chk("bp_in_ready",  {31'h0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
        saved_d = d;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_d_stable",   {16'h0, d}, {16'h0, saved_d});
        chk("bp_still_three", n_acc - base_acc, 32'd3);
        out_ready = 1'b1;
        for (int t = 0; t < 100 && !bp_done; t++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_sender_done", {31'h0, bp_done}, 32'd1);
        drain();
        chk("bp_out_count", n_out - base_out, 32'd5);

        // Mid-stream asynchronous reset with three results in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            send(ra, rb, 1'b0, model(ra, rb, 1'b0), 1'b0);
        end
        in_valid = 1'b0;
        #2;
        chk("pre_rst_full", {31'h0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("arst_d",         {16'h0, d},         32'd0);
        chk("arst_bout",      {31'h0, bout},      32'd0);
        q_exp.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_stale", {31'h0, out_valid}, 32'd0);
        end
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'd1);
        base_out = n_out;
        send(16'h0005, 16'h0003, 1'b0, model(16'h0005, 16'h0003, 1'b0), 1'b1);
        in_valid = 1'b0;
        drain();
        chk("post_rst_result_count", n_out - base_out, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
